// File: rtl/syncv_pkg.sv
// Frame-standard encodings and per-mode vertical timing constants for syncv_multi.
package syncv_pkg;

    localparam logic [1:0] MODE_PENT = 2'd0;
    localparam logic [1:0] MODE_128  = 2'd1;
    localparam logic [1:0] MODE_48   = 2'd2;
    localparam logic [1:0] MODE_60   = 2'd3;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] vblnk_end;
        logic [15:0] vsync_beg;
        logic [15:0] vsync_end;
        logic [15:0] vpix_beg;
        logic [15:0] vpix_end;
    } timing_t;

    function automatic timing_t mode_timing(input logic [1:0] mode);
        timing_t t;
        case (mode)
            MODE_PENT: t = '{period: 16'd320, vblnk_end: 16'd32, vsync_beg: 16'd8,
                             vsync_end: 16'd11, vpix_beg: 16'd80, vpix_end: 16'd272};
            MODE_128:  t = '{period: 16'd311, vblnk_end: 16'd24, vsync_beg: 16'd4,
                             vsync_end: 16'd7,  vpix_beg: 16'd63, vpix_end: 16'd255};
            MODE_48:   t = '{period: 16'd312, vblnk_end: 16'd24, vsync_beg: 16'd4,
                             vsync_end: 16'd7,  vpix_beg: 16'd64, vpix_end: 16'd256};
            default:   t = '{period: 16'd262, vblnk_end: 16'd16, vsync_beg: 16'd3,
                             vsync_end: 16'd6,  vpix_beg: 16'd24, vpix_end: 16'd216};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/int_stretch.sv
// Stretches a one-clk trigger into an INT_LEN-clk active level; retrigger reloads.
module int_stretch #(
    parameter int INT_LEN = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    output logic active_o
);

    logic [15:0] cnt_q;
    logic        active_q;

    // cnt_q holds the clocks still to go after the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (trig_i) begin
            cnt_q    <= 16'(INT_LEN - 1);
            active_q <= 1'b1;
        end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - 16'd1;
        end else begin
            active_q <= 1'b0;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/syncv_multi.sv
// Vertical timing generator: line counter, blank/sync/picture windows and Z80 INT,
// with the frame standard switched only at the frame wrap.
module syncv_multi
    import syncv_pkg::*;
#(
    parameter int         CW       = 9,
    parameter int         INT_LEN  = 32,
    parameter logic [1:0] DEF_MODE = 2'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync_start,
    input  logic          line_start,
    input  logic          hint_start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] int_line,
    output logic [CW-1:0] vcount,
    output logic          frame_start,
    output logic          vblank,
    output logic          vsync,
    output logic          vpix,
    output logic          int_start,
    output logic          int_active,
    output logic [1:0]    cur_mode
);

    logic [CW-1:0] vcount_q, vcount_d;
    logic [1:0]    cur_mode_q, cur_mode_d;
    logic          frame_start_q, frame_start_d;
    logic          vblank_q, vblank_d;
    logic          vsync_q, vsync_d;
    logic          vpix_q, vpix_d;
    logic          int_start_q, int_start_d;

    timing_t       tim;
    logic [CW-1:0] last_line, vblnk_end, vsync_beg, vsync_end, vpix_beg, vpix_end;

    // Timing always follows the shadow mode, never the live request
    assign tim       = mode_timing(cur_mode_q);
    assign last_line = CW'(tim.period - 16'd1);
    assign vblnk_end = CW'(tim.vblnk_end);
    assign vsync_beg = CW'(tim.vsync_beg);
    assign vsync_end = CW'(tim.vsync_end);
    assign vpix_beg  = CW'(tim.vpix_beg);
    assign vpix_end  = CW'(tim.vpix_end);

    always_comb begin
        vcount_d      = vcount_q;
        cur_mode_d    = cur_mode_q;
        frame_start_d = 1'b0;
        vblank_d      = vblank_q;
        vsync_d       = vsync_q;
        vpix_d        = vpix_q;

        if (hsync_start) begin
            if (vcount_q == last_line) begin
                vcount_d      = '0;
                cur_mode_d    = mode;
                frame_start_d = 1'b1;
            end else begin
                vcount_d = vcount_q + CW'(1);
            end

            if (vcount_q == '0)            vblank_d = 1'b1;
            else if (vcount_q == vblnk_end) vblank_d = 1'b0;

            if (vcount_q == vpix_beg)      vpix_d = 1'b1;
            else if (vcount_q == vpix_end) vpix_d = 1'b0;
        end

        // vsync ends on the mid-line strobe, not on the line advance
        if (hsync_start && vcount_q == vsync_beg)     vsync_d = 1'b1;
        else if (line_start && vcount_q == vsync_end) vsync_d = 1'b0;

        int_start_d = hint_start && (vcount_q == int_line);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcount_q      <= '0;
            cur_mode_q    <= DEF_MODE;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
            vsync_q       <= 1'b0;
            vpix_q        <= 1'b0;
            int_start_q   <= 1'b0;
        end else begin
            vcount_q      <= vcount_d;
            cur_mode_q    <= cur_mode_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            vpix_q        <= vpix_d;
            int_start_q   <= int_start_d;
        end
    end

    int_stretch #(.INT_LEN(INT_LEN)) u_int_stretch (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig_i   (int_start_d),
        .active_o (int_active)
    );

    assign vcount      = vcount_q;
    assign cur_mode    = cur_mode_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;
    assign vsync       = vsync_q;
    assign vpix        = vpix_q;
    assign int_start   = int_start_q;

endmodule

// File: tb/tb_syncv_multi.sv
// Randomised line stimulus for syncv_multi checked against a line-level reference model.
module tb_syncv_multi;

    localparam int         CW       = 9;
    localparam int         INT_LEN  = 32;
    localparam logic [1:0] DEF_MODE = 2'd0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hsync_start, line_start, hint_start;
    logic [1:0]    mode;
    logic [CW-1:0] int_line;
    logic [CW-1:0] vcount;
    logic          frame_start, vblank, vsync, vpix, int_start, int_active;
    logic [1:0]    cur_mode;

    syncv_multi #(.CW(CW), .INT_LEN(INT_LEN), .DEF_MODE(DEF_MODE)) dut (
        .clk(clk), .rst_n(rst_n), .hsync_start(hsync_start), .line_start(line_start),
        .hint_start(hint_start), .mode(mode), .int_line(int_line), .vcount(vcount),
        .frame_start(frame_start), .vblank(vblank), .vsync(vsync), .vpix(vpix),
        .int_start(int_start), .int_active(int_active), .cur_mode(cur_mode)
    );

    always #5 clk = ~clk;

    // Frame standards: Pentagon, 128K, 48K, 60Hz
    int PER[4] = '{320, 311, 312, 262};
    int VBE[4] = '{32, 24, 24, 16};
    int VSB[4] = '{8, 4, 4, 3};
    int VSE[4] = '{11, 7, 7, 6};
    int VPB[4] = '{80, 63, 64, 24};
    int VPE[4] = '{272, 255, 256, 216};

    int checks = 0;
    int errors = 0;

    int m_vc, m_mode, m_rem;
    bit m_vsync, m_fs, m_ints;
    int hint_mode;
    int lines, last_len, ints_cnt, inta_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vc = 0; m_mode = int'(DEF_MODE); m_rem = 0;
        m_vsync = 0; m_fs = 0; m_ints = 0; lines = 0;
    endtask

    task automatic cyc(input bit hs, input bit ls, input bit hi);
        @(negedge clk);
        hsync_start = hs; line_start = ls; hint_start = hi;
        @(posedge clk);
        #1;
        hsync_start = 0; line_start = 0; hint_start = 0;
        m_fs   = hs && (m_vc == PER[m_mode] - 1);
        m_ints = hi && (m_vc == int'(int_line));
        if (hs && m_vc == VSB[m_mode])      m_vsync = 1;
        else if (ls && m_vc == VSE[m_mode]) m_vsync = 0;
        if (m_ints)         m_rem = INT_LEN;
        else if (m_rem > 0) m_rem--;
        if (hs) begin
            if (m_fs) begin m_vc = 0; m_mode = int'(mode); end
            else m_vc++;
        end
        chk("vcount", 32'(vcount), 32'(m_vc));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("vblank", 32'(vblank), 32'(m_vc >= 1 && m_vc <= VBE[m_mode]));
        chk("vsync", 32'(vsync), 32'(m_vsync));
        chk("vpix", 32'(vpix), 32'(m_vc > VPB[m_mode] && m_vc <= VPE[m_mode]));
        chk("int_start", 32'(int_start), 32'(m_ints));
        chk("int_active", 32'(int_active), 32'(m_rem > 0));
        chk("cur_mode", 32'(cur_mode), 32'(m_mode));
        if (hs) lines++;
        if (frame_start) begin last_len = lines; lines = 0; end
        if (int_start) ints_cnt++;
        if (int_active) inta_cnt++;
    endtask

    task automatic line(input int len, input int ls_pos, input int hi_pos);
        for (int c = 0; c < len; c++) cyc(c == len - 1, c == ls_pos, c == hi_pos);
    endtask

    task automatic auto_line();
        int len, ls, hi;
        len = $urandom_range(4, 10);
        ls  = $urandom_range(0, len - 1);
        hi  = -1;
        if (m_vc == VSB[m_mode])      ls = len - 1;
        else if (m_vc == VSE[m_mode]) ls = len / 2;
        if (hint_mode == 2 || (hint_mode == 1 && $urandom_range(0, 1) == 1))
            hi = $urandom_range(0, len - 1);
        line(len, ls, hi);
    endtask

    task automatic run_to_wrap();
        for (int i = 0; i < 400; i++) begin
            auto_line();
            if (m_fs) break;
        end
        chk("wrap_vcount", 32'(vcount), 32'd0);
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 400; i++) begin
            if (m_vc == target) break;
            auto_line();
        end
        chk("reach_vcount", 32'(vcount), 32'(target));
    endtask

    initial begin
        rst_n = 0; hsync_start = 0; line_start = 0; hint_start = 0;
        mode = 2'd0; int_line = 9'd10; hint_mode = 1;
        last_len = 0; ints_cnt = 0; inta_cnt = 0;
        model_reset();
        #12;
        chk("rst_vcount", 32'(vcount), 32'd0);
        chk("rst_outs", 32'({frame_start, vblank, vsync, vpix, int_start, int_active}), 32'd0);
        chk("rst_cur_mode", 32'(cur_mode), 32'(DEF_MODE));
        @(negedge clk) rst_n = 1;

        // Pentagon frames with random line lengths, strobe positions and hints
        run_to_wrap();
        chk("frame_len_pent", 32'(last_len), 32'd320);
        run_to_wrap();
        chk("frame_len_pent2", 32'(last_len), 32'd320);

        // Mid-frame request for 60Hz is held off until the wrap
        int_line = 9'd150;
        run_until(100);
        mode = 2'd3;
        run_until(319);
        chk("cur_mode_held", 32'(cur_mode), 32'd0);
        run_to_wrap();
        chk("cur_mode_switched", 32'(cur_mode), 32'd3);
        run_to_wrap();
        chk("frame_len_60", 32'(last_len), 32'd262);

        // Single INT in 128K mode
        mode = 2'd1; hint_mode = 0; int_line = 9'd5;
        run_to_wrap();
        run_until(5);
        ints_cnt = 0; inta_cnt = 0;
        line(6, -1, 2);
        for (int i = 0; i < 10; i++) auto_line();
        chk("single_int_pulses", 32'(ints_cnt), 32'd1);
        chk("single_int_len", 32'(inta_cnt), 32'(INT_LEN));

        // INT line beyond the frame never fires
        int_line = 9'd400; hint_mode = 2; ints_cnt = 0;
        for (int f = 0; f < 3; f++) run_to_wrap();
        chk("no_int_pulses", 32'(ints_cnt), 32'd0);
        chk("frame_len_128", 32'(last_len), 32'd311);

        // Retrigger 10 clks apart
        int_line = 9'd5; hint_mode = 0;
        run_until(5);
        ints_cnt = 0; inta_cnt = 0;
        for (int c = 0; c < 60; c++) cyc(c == 59, 0, c == 3 || c == 13);
        for (int i = 0; i < 10; i++) auto_line();
        chk("retrig_pulses", 32'(ints_cnt), 32'd2);
        chk("retrig_len", 32'(inta_cnt), 32'(INT_LEN + 10));

        // Asynchronous reset in the middle of an INT
        int_line = 9'd200;
        run_until(200);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_vcount", 32'(vcount), 32'd0);
        chk("arst_outs", 32'({frame_start, vblank, vsync, vpix, int_start, int_active}), 32'd0);
        chk("arst_cur_mode", 32'(cur_mode), 32'(DEF_MODE));
        model_reset();
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 3; i++) auto_line();
        chk("post_rst_cur_mode", 32'(cur_mode), 32'(DEF_MODE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/syncv_multi.md
Name: syncv_multi

Overview:
Parametrised successor vertical timing generator for the video path. It counts lines on hsync_start and produces vblank, vsync, vpix and the Z80 INT start pulse. Four frame standards are selectable at runtime; a mode change takes effect only at a frame boundary. It adds a programmable INT line, a stretched INT output and line/frame-start outputs for downstream raster logic.

Parameters:
CW, 9, line counter width (≥ 9; every mode constant must fit).
INT_LEN, 32, INT active length in clk cycles (1..2^16-1).
DEF_MODE, 2'd0, mode loaded into the shadow register at reset.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hsync_start  in  1  one-clk pulse; line advance strobe
line_start  in  1  one-clk pulse; ends vsync
hint_start  in  1  one-clk pulse; horizontal INT position
mode  in  2  requested standard: 0 Pentagon, 1 128K, 2 48K, 3 60Hz
int_line  in  CW  line on which INT fires
vcount  out  CW  current line number
frame_start  out  1  one-clk pulse when vcount wraps to 0
vblank  out  1  vertical blank
vsync  out  1  vertical sync
vpix  out  1  vertical picture window
int_start  out  1  one-clk INT start pulse
int_active  out  1  INT held for INT_LEN clks
cur_mode  out  2  mode currently in effect (shadow)

Behaviour:
- Reset (async, rst_n=0): vcount=0, frame_start, vblank, vsync, vpix, int_start and int_active=0, INT counter=0, cur_mode=DEF_MODE.
- Mode constants (PERIOD, VBLNK_END, VSYNC_BEG, VSYNC_END, VPIX_BEG, VPIX_END; VBLNK_BEG=0 in all modes):
  - Pentagon: 320, 32, 8, 11, 80, 272.
  - 128K: 311, 24, 4, 7, 63, 255.
  - 48K: 312, 24, 4, 7, 64, 256.
  - 60Hz: 262, 16, 3, 6, 24, 216.
- Counter: on hsync_start, if vcount==PERIOD-1 then vcount←0, cur_mode←mode, frame_start=1 for that next cycle; otherwise vcount←vcount+1.
- Constants are always taken from cur_mode, never from the raw mode input. A mode change mid-frame has no effect until the wrap.
- The wrap compare uses equality only. After reset, or after a wrap into a shorter mode, vcount is always < PERIOD, so no overrun is possible.
- vblank: on hsync_start, set when vcount==0; cleared when vcount==VBLNK_END. Set has priority.
- vsync: set when vcount==VSYNC_BEG and hsync_start; cleared when vcount==VSYNC_END and line_start. If both occur in the same clk, set wins.
- vpix: on hsync_start, set when vcount==VPIX_BEG; cleared when vcount==VPIX_END.
- All outputs are registered, so each change appears 1 clk after its qualifying strobe.
- int_start: 1-clk pulse, registered, when hint_start and vcount==int_line. If int_line ≥ PERIOD, no INT fires.
- int_active: rises with int_start and stays high for exactly INT_LEN clks via a down-counter.
  - A new int_start while active reloads the counter (retrigger).
  - A reset mid-INT clears it immediately.
- int_line is sampled live. A change takes effect on the next matching compare.

Decomposition:
- Package syncv_pkg holds:
  - mode encoding localparams: MODE_PENT, MODE_128, MODE_48, MODE_60;
  - a per-mode constant record type with the six fields;
  - a function mode_timing(mode) returning that record.
- Sub-module int_stretch (INT_LEN down-counter, retrigger, int_active) is natural and reusable for the horizontal INT.

Test Plan:
- Reset then mode=0, hsync_start every 448 clk → vcount wraps 319→0; frame_start once per 320 lines; vblank high on lines 1..32; vpix high on lines 81..272 (one-line register lag).
- Switch mode 0→3 at vcount=100 → cur_mode stays 0 until the wrap after line 319; the next frame has 262 lines and vsync asserts at vcount=3.
- vsync end: line_start at vcount=11 mid-line → vsync drops 1 clk after line_start, not at hsync_start; simultaneous hsync_start+line_start at VSYNC_BEG → vsync=1.
- int_line=5, mode 1 → int_start single pulse at hint_start of line 5; int_active high exactly 32 clks. With int_line=400 → no pulse over 3 frames.
- Retrigger: hint_start twice 10 clks apart on a matching line → int_active high 42 clks total.
- Assert rst_n=0 at vcount=200 while int_active=1 → all outputs 0 asynchronously; cur_mode=DEF_MODE after release.
